// File: rtl/memb_skew_stream_pkg.sv
// Shared types and helpers for the skewed B-operand staging buffer.
package memb_skew_stream_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } memb_state_t;

   // Width of the stream cycle counter, which must reach 2*dim-2.
   function automatic int cnt_bits(input int dim);
      return $clog2(2 * dim);
   endfunction

endpackage

// File: rtl/memb_skew_stream_if.sv
// Host-side bus of the B staging buffer: tile load, control and skewed output stream.
interface memb_skew_stream_if #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
);
   localparam int ROWBITS = $clog2(DIM);

   logic                             wr_en;
   logic [ROWBITS-1:0]               wr_row;
   logic [DIM-1:0][BITS_AB-1:0]      Bin;
   logic                             clr;
   logic                             start;
   logic                             transpose;
   logic                             busy;
   logic                             Bvalid;
   logic [DIM-1:0][BITS_AB-1:0]      Bout;
   logic                             done;

   modport master (
      output wr_en, wr_row, Bin, clr, start, transpose,
      input  busy, Bvalid, Bout, done
   );

   modport slave (
      input  wr_en, wr_row, Bin, clr, start, transpose,
      output busy, Bvalid, Bout, done
   );

endinterface

// File: rtl/memb_skew_stream_tile_store.sv
// DIM x DIM tile register file with a row write port, whole-tile clear and a
// combinational column-skewed read (element c comes from diagonal t-c).
module memb_skew_stream_tile_store
   import memb_skew_stream_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int ROWBITS = $clog2(DIM),
   parameter int CNTBITS = cnt_bits(DIM)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en_i,
   input  logic [ROWBITS-1:0]           wr_row_i,
   input  logic [DIM-1:0][BITS_AB-1:0]  wr_data_i,
   input  logic                         clr_i,
   input  logic [CNTBITS-1:0]           t_i,
   input  logic                         transpose_i,
   output logic [DIM-1:0][BITS_AB-1:0]  rd_data_o
);

   localparam logic signed [CNTBITS:0] IDX_DIM = (CNTBITS+1)'(DIM);

   logic [DIM-1:0][DIM-1:0][BITS_AB-1:0] tile_q, tile_d;
   logic signed [CNTBITS:0]              idx;
   logic [ROWBITS-1:0]                   row;

   // Next tile contents: clear has priority over a row write.
   always_comb begin
      tile_d = tile_q;
      if (clr_i) begin
         tile_d = '0;
      end else if (wr_en_i && (int'(wr_row_i) < DIM)) begin
         tile_d[wr_row_i] = wr_data_i;
      end
   end

   // Tile storage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_q <= '0;
      end else begin
         tile_q <= tile_d;
      end
   end

   // Skewed read: one extra sign bit on t-c flags columns not yet (or no longer) in the window.
   always_comb begin
      rd_data_o = '0;
      idx       = '0;
      row       = '0;
      for (int c = 0; c < DIM; c++) begin
         idx = $signed({1'b0, t_i}) - $signed((CNTBITS+1)'(c));
         row = idx[ROWBITS-1:0];
         if (!idx[CNTBITS] && (idx < IDX_DIM)) begin
            rd_data_o[c] = transpose_i ? tile_q[c][row] : tile_q[row][c];
         end
      end
   end

endmodule

// File: rtl/memb_skew_stream.sv
// B-operand staging buffer for the systolic array: loads a tile row by row,
// then streams it column-skewed for 2*DIM-1 cycles with a start/busy/done handshake.
module memb_skew_stream
   import memb_skew_stream_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   memb_skew_stream_if.slave  bus
);

   localparam int ROWBITS = $clog2(DIM);
   localparam int CNTBITS = cnt_bits(DIM);
   localparam logic [CNTBITS-1:0] LAST_T = CNTBITS'(2 * DIM - 2);

   memb_state_t                  state_q, state_d;
   logic [CNTBITS-1:0]           cnt_q, cnt_d;
   logic                         tr_q, tr_d;
   logic [DIM-1:0][BITS_AB-1:0]  bout_q, bout_d;
   logic                         bvalid_q, bvalid_d;
   logic                         done_q, done_d;
   logic [DIM-1:0][BITS_AB-1:0]  rd_data;
   logic                         busy;

   assign busy = (state_q == STREAM);

   // Tile is frozen while streaming, so loads and clears are gated by busy.
   memb_skew_stream_tile_store #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROWBITS (ROWBITS),
      .CNTBITS (CNTBITS)
   ) u_store (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (bus.wr_en & ~busy),
      .wr_row_i    (bus.wr_row),
      .wr_data_i   (bus.Bin),
      .clr_i       (bus.clr & ~busy),
      .t_i         (cnt_q),
      .transpose_i (tr_q),
      .rd_data_o   (rd_data)
   );

   // Next state, stream counter and registered output values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tr_d     = tr_q;
      bout_d   = '0;
      bvalid_d = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = STREAM;
               cnt_d   = '0;
               tr_d    = bus.transpose;
            end
         end
         STREAM: begin
            bout_d   = rd_data;
            bvalid_d = 1'b1;
            done_d   = (cnt_q == LAST_T);
            if (cnt_q == LAST_T) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTBITS'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tr_q     <= 1'b0;
         bout_q   <= '0;
         bvalid_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tr_q     <= tr_d;
         bout_q   <= bout_d;
         bvalid_q <= bvalid_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = busy;
   assign bus.Bvalid = bvalid_q;
   assign bus.Bout   = bout_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_memb_skew_stream.sv
// Scoreboard bench for memb_skew_stream (DIM=8, BITS_AB=8): the stimulus pushes
// expected stream cycles, a negedge monitor pops and compares each valid output.
module tb_memb_skew_stream;

   typedef logic [7:0][7:0] row_t;
   typedef struct packed {
      row_t bout;
      logic done;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int   checks = 0;
   int   errors = 0;
   int   vidx   = 0;
   row_t cap [32];
   exp_t sbq [$];
   logic [7:0] model [8][8];

   memb_skew_stream_if #(.BITS_AB(8), .DIM(8)) bus ();

   memb_skew_stream #(.BITS_AB(8), .DIM(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic row_t exp_row(input int t, input bit tr);
      row_t r = '0;
      for (int c = 0; c < 8; c++) begin
         int i = t - c;
         if (i >= 0 && i < 8) r[c] = tr ? model[c][i] : model[i][c];
      end
      return r;
   endfunction

   task automatic push_pass(input bit tr);
      exp_t e;
      for (int t = 0; t < 15; t++) begin
         e.bout = exp_row(t, tr);
         e.done = (t == 14);
         sbq.push_back(e);
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) model[r][c] = 8'd0;
   endtask

   task automatic write_row(input int r, input row_t d);
      bus.wr_en  = 1'b1;
      bus.wr_row = 3'(r);
      bus.Bin    = d;
      @(posedge clk); #1;
      bus.wr_en  = 1'b0;
      for (int c = 0; c < 8; c++) model[r][c] = d[c];
   endtask

   task automatic load_tile();
      row_t d;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) d[c] = 8'(r * 8 + c);
         write_row(r, d);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy === 1'b1 && n < 100);
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", name, bus.busy, n);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   // One pass: optional clear on the start edge, optional writes attempted while busy.
   task automatic run_pass(input string name, input bit tr, input bit poke, input bit with_clr);
      vidx = 0;
      if (with_clr) clear_model();
      push_pass(tr);
      bus.start     = 1'b1;
      bus.transpose = tr;
      bus.clr       = with_clr;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.transpose = 1'b0;
      bus.clr       = 1'b0;
      chk({name, "_busy"}, 64'(bus.busy), 64'd1);
      if (poke) begin
         bus.wr_en  = 1'b1;
         bus.wr_row = 3'd3;
         bus.Bin    = {8{8'h80}};
         bus.clr    = 1'b0;
         repeat (3) begin @(posedge clk); #1; end
         bus.wr_en  = 1'b0;
      end
      wait_idle(name);
      chk({name, "_valid_count"}, 64'(vidx), 64'd15);
      chk({name, "_sb_drained"}, 64'(sbq.size()), 64'd0);
   endtask

   // Monitor: compares each valid cycle with the scoreboard; idle cycles must be quiet.
   always @(negedge clk) begin
      exp_t e;
      if (bus.Bvalid === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got Bout %h done %b with no pass expected", bus.Bout, bus.done);
         end else begin
            e = sbq.pop_front();
            if (bus.Bout !== e.bout || bus.done !== e.done) begin
               errors++;
               $display("FAIL sb_stream t=%0d: got Bout %h done %b expected Bout %h done %b",
                        vidx, bus.Bout, bus.done, e.bout, e.done);
            end
         end
         if (vidx < 32) cap[vidx] = bus.Bout;
         vidx++;
      end else if (rst_n === 1'b1) begin
         checks++;
         if (bus.done !== 1'b0 || bus.Bout !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got Bout %h done %b expected 0 and 0", bus.Bout, bus.done);
         end
      end
   end

   initial begin
      logic [39:0] act_v, exp_v;
      int n;
      bus.wr_en = 1'b0; bus.wr_row = '0; bus.Bin = '0;
      bus.clr = 1'b0; bus.start = 1'b0; bus.transpose = 1'b0;
      clear_model();

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", 64'({bus.busy, bus.Bvalid, bus.done}), 64'd0);
      chk("reset_bout", bus.Bout, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Abort a zero-tile pass with reset while it is mid-stream.
      vidx = 0;
      push_pass(1'b0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (vidx < 6 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk("midreset_reached_t5", 64'(vidx >= 6), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_ctrl", 64'({bus.busy, bus.Bvalid, bus.done}), 64'd0);
      chk("midreset_bout", bus.Bout, 64'd0);
      sbq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_pass("zero_after_reset", 1'b0, 1'b0, 1'b0);

      // Ramp tile B[r][c] = r*8+c, normal orientation.
      load_tile();
      run_pass("ramp", 1'b0, 1'b0, 1'b0);
      chk("ramp_t0", cap[0], 64'd0);
      chk("ramp_t7_c7", 64'(cap[7][7]), 64'd7);
      chk("ramp_t7_c0", 64'(cap[7][0]), 64'd56);
      chk("ramp_t14", cap[14], {8'd63, 56'd0});

      // Same tile reused, transposed.
      run_pass("transpose", 1'b1, 1'b0, 1'b0);
      chk("tr_t1_c0", 64'(cap[1][0]), 64'd1);
      chk("tr_t1_c1", 64'(cap[1][1]), 64'd8);

      // Writes while streaming must be ignored.
      run_pass("poke", 1'b0, 1'b1, 1'b0);
      run_pass("after_poke", 1'b0, 1'b0, 1'b0);
      chk("after_poke_b30", 64'(cap[3][0]), 64'd24);
      chk("after_poke_b37", 64'(cap[10][7]), 64'd31);

      // Clear wins over a same-cycle write.
      bus.clr    = 1'b1;
      bus.wr_en  = 1'b1;
      bus.wr_row = 3'd0;
      bus.Bin    = {8{8'd5}};
      @(posedge clk); #1;
      bus.clr    = 1'b0;
      bus.wr_en  = 1'b0;
      clear_model();
      run_pass("clr_wr", 1'b0, 1'b0, 1'b0);
      chk("clr_wr_row0", cap[0], 64'd0);

      // Clear on the start edge: the pass must see the cleared tile.
      load_tile();
      run_pass("clr_start", 1'b0, 1'b0, 1'b1);
      chk("clr_start_b70", 64'(cap[7][0]), 64'd0);

      // Back-to-back passes with start held high.
      load_tile();
      vidx = 0;
      push_pass(1'b0);
      push_pass(1'b0);
      bus.start = 1'b1;
      act_v = '0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         act_v[i] = bus.Bvalid;
         if (i == 20) bus.start = 1'b0;
      end
      exp_v = '0;
      for (int i = 0; i < 40; i++) exp_v[i] = (i >= 1 && i <= 15) || (i >= 17 && i <= 31);
      chk("b2b_valid_pattern", 64'(act_v), 64'(exp_v));
      chk("b2b_valid_count", 64'(vidx), 64'd30);
      chk("b2b_sb_drained", 64'(sbq.size()), 64'd0);
      chk("b2b_t7_pass2", 64'(cap[22][0]), 64'd56);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
